mult_div_unit: RTL and testbench
================================

Name: mult_div_unit

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, sitting directly downstream of the register file.
- Consumes the two register read operands (rs → a, rt → b); produces hi/lo for the writeback mux (MFHI/MFLO).
- Models MIPS MULT/MULTU/DIV/DIVU latency with a busy flag so the hazard/stall logic can hold dependent instructions.
- Also services MTHI/MTLO single-cycle writes.

Parameters:
- MULT_CYCLES, 5, busy duration for MULT/MULTU (must be ≥1).
- DIV_CYCLES, 10, busy duration for DIV/DIVU (must be ≥1).

Ports:
- clk  in  1  clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request valid this cycle.
- op  in  3  0=MULT, 1=MULTU, 2=DIV, 3=DIVU, 4=MTHI, 5=MTLO; 6,7 reserved (ignored).
- a  in  32  operand A (rs read data).
- b  in  32  operand B (rt read data).
- iaddr  in  32  PC of issuing instruction; used only for the trace feature.
- busy  out  1  operation in flight.
- hi  out  32  HI register.
- lo  out  32  LO register.

Behaviour:
- Reset (edge with reset=1): hi=0, lo=0, busy=0, counter=0, pending results cleared. Reset wins over every other event, including an in-flight op (cancelled, no commit) and a simultaneous start (ignored).
- Idle accept (busy=0, start=1, op 0..3) at edge T:
  - latch computed 64-bit result into pending regs;
  - busy<=1;
  - counter<=MULT_CYCLES or DIV_CYCLES.
- Countdown: each later edge decrements counter. The edge where counter==1 writes pending to hi/lo and sets busy<=0. Net effect: busy is high for exactly N cycles; new hi/lo is visible after edge T+N.
- hi/lo hold their old values during busy. MFHI/MFLO stalling is the controller's job.
- start while busy=1: ignored entirely (no restart, no MTHI/MTLO effect). Controller must stall instead.
- MTHI/MTLO with busy=0: hi<=a (or lo<=a) at that edge; busy stays 0.
- Reserved op with start: no effect.
- MULT: signed 32x32→64; hi=[63:32], lo=[31:0]. MULTU: unsigned.
- DIV: signed, truncating toward zero; lo=quotient, hi=remainder (sign of dividend).
- DIVU: unsigned.
- Divide by zero (DIV/DIVU, b=0): full latency still taken; hi=a, lo=32'hFFFFFFFF.
- DIV overflow (a=32'h80000000, b=32'hFFFFFFFF): lo=32'h80000000, hi=0.
- Back-to-back: a start in the cycle busy falls (same edge as commit) is not accepted. The next op can be accepted one cycle after busy deasserts.

Optional Feature:
- Macro MD_TRACE_EN.
- Defined: on every hi/lo write, $display("@%h: HI <= %h", ...) and/or ("@%h: LO <= %h", ...) with the iaddr captured at accept time (MTHI/MTLO use current iaddr). Lines for hi and lo are printed separately, hi first.
- Undefined: no display; iaddr unused. Functional behaviour is identical either way.

Decomposition:
- Shared package md_pkg holds op encodings (MD_MULT..MD_MTLO), default latency constants, and the divide-by-zero fill constant.
- Arithmetic (64-bit result selection, including zero/overflow special cases) is a natural combinational sub-module md_calc.
- Counter/busy/commit logic stays in mult_div_unit.

Test Plan:
- Reset then idle: hi=lo=0, busy=0. MTHI a=32'h12345678 → hi=32'h12345678 next edge, busy stays 0.
- MULT a=32'hFFFFFFFE(-2), b=3 → busy high 5 cycles; hi=32'hFFFFFFFF, lo=32'hFFFFFFFA after edge T+5. Old hi/lo stable while busy.
- DIVU a=7, b=0 → busy 10 cycles, then hi=7, lo=32'hFFFFFFFF. DIV a=-7, b=2 → lo=32'hFFFFFFFD, hi=32'hFFFFFFFF.
- DIV a=32'h80000000, b=32'hFFFFFFFF → lo=32'h80000000, hi=0. A second start issued while busy (MTLO a=5) leaves lo unaffected.
- Assert reset at cycle 3 of a MULTU 100000×100000 → busy=0, hi=lo=0. The result is never committed.
- Two MULTUs issued the cycle after busy falls → each completes in 5 cycles. A start on the commit edge itself is dropped.

Source files
------------

// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings,
// default latencies and the divide-by-zero quotient fill value.
package md_pkg;

    typedef enum logic [2:0] {
        MD_MULT  = 3'd0,
        MD_MULTU = 3'd1,
        MD_DIV   = 3'd2,
        MD_DIVU  = 3'd3,
        MD_MTHI  = 3'd4,
        MD_MTLO  = 3'd5
    } md_op_e;

    localparam int MD_MULT_CYCLES_DEF = 5;
    localparam int MD_DIV_CYCLES_DEF  = 10;

    // LO value written when a divide has a zero divisor
    localparam logic [31:0] MD_DIVZ_LO = 32'hFFFF_FFFF;

endpackage

// File: rtl/md_calc.sv
// Combinational 64-bit result generator for MULT/MULTU/DIV/DIVU.
// Result layout is {hi, lo}; divides give {remainder, quotient}.
// Zero divisor and the signed INT_MIN / -1 overflow are resolved here so
// the sequencer only has to latch a finished value.
module md_calc
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result
);

    logic signed [63:0] a_sx;
    logic signed [63:0] b_sx;
    logic signed [63:0] prod_s;
    logic        [63:0] prod_u;
    logic signed [31:0] a_s;
    logic signed [31:0] b_div_s;
    logic signed [31:0] quot_s;
    logic signed [31:0] rem_s;
    logic        [31:0] b_div_u;
    logic        [31:0] quot_u;
    logic        [31:0] rem_u;
    logic               b_zero;
    logic               div_ovf;

    assign a_sx   = {{32{a[31]}}, a};
    assign b_sx   = {{32{b[31]}}, b};
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'd0, a} * {32'd0, b};

    assign b_zero  = (b == 32'd0);
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);

    // Special cases divide by 1 instead so the datapath never sees a
    // zero divisor or an unrepresentable quotient; their results are
    // overridden below.
    assign a_s     = a;
    assign b_div_s = (b_zero || div_ovf) ? 32'sd1 : b;
    assign b_div_u = b_zero ? 32'd1 : b;

    assign quot_s = a_s / b_div_s;
    assign rem_s  = a_s % b_div_s;
    assign quot_u = a / b_div_u;
    assign rem_u  = a % b_div_u;

    // Select the 64-bit {hi, lo} value for the requested operation
    always_comb begin
        result = 64'd0;
        case (op)
            MD_MULT:  result = $unsigned(prod_s);
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                if (b_zero)
                    result = {a, MD_DIVZ_LO};
                else if (div_ovf)
                    result = {32'd0, 32'h8000_0000};
                else
                    result = {$unsigned(rem_s), $unsigned(quot_s)};
            end
            MD_DIVU: begin
                if (b_zero)
                    result = {a, MD_DIVZ_LO};
                else
                    result = {rem_u, quot_u};
            end
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// MULT/MULTU/DIV/DIVU hold busy for MULT_CYCLES/DIV_CYCLES cycles and
// commit at the end; MTHI/MTLO write immediately. Starts while busy are
// dropped, the stall logic upstream is expected to hold them.
// Optional macro MD_TRACE_EN prints every HI/LO write with its PC.
module mult_div_unit
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = MD_MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = MD_DIV_CYCLES_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] iaddr,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    logic [CNT_W-1:0] count;
    logic [31:0]      pend_hi;
    logic [31:0]      pend_lo;
    logic [63:0]      calc_result;
    logic             idle_start;
    logic             accept_mul;
    logic             accept_div;
    logic             commit;

    md_calc u_calc (
        .op     (op),
        .a      (a),
        .b      (b),
        .result (calc_result)
    );

    assign idle_start = start && !busy;
    assign accept_mul = idle_start && ((op == MD_MULT) || (op == MD_MULTU));
    assign accept_div = idle_start && ((op == MD_DIV)  || (op == MD_DIVU));
    assign commit     = busy && (count == CNT_W'(1));

    // Accept, count down and commit; MTHI/MTLO write straight through when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            busy    <= 1'b0;
            count   <= '0;
            pend_hi <= 32'd0;
            pend_lo <= 32'd0;
            hi      <= 32'd0;
            lo      <= 32'd0;
        end else if (busy) begin
            if (commit) begin
                hi    <= pend_hi;
                lo    <= pend_lo;
                busy  <= 1'b0;
                count <= '0;
            end else begin
                count <= count - CNT_W'(1);
            end
        end else if (accept_mul || accept_div) begin
            pend_hi <= calc_result[63:32];
            pend_lo <= calc_result[31:0];
            busy    <= 1'b1;
            count   <= accept_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
        end else if (idle_start && (op == MD_MTHI)) begin
            hi <= a;
        end else if (idle_start && (op == MD_MTLO)) begin
            lo <= a;
        end
    end

`ifdef MD_TRACE_EN
    logic [31:0] pend_iaddr;

    // Remember the PC of the accepted multi-cycle op for its commit trace
    always_ff @(posedge clk) begin
        if (accept_mul || accept_div)
            pend_iaddr <= iaddr;
    end

    // Report each HI/LO write, HI line first
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (commit) begin
                $display("@%h: HI <= %h", pend_iaddr, pend_hi);
                $display("@%h: LO <= %h", pend_iaddr, pend_lo);
            end else if (idle_start && (op == MD_MTHI)) begin
                $display("@%h: HI <= %h", iaddr, a);
            end else if (idle_start && (op == MD_MTLO)) begin
                $display("@%h: LO <= %h", iaddr, a);
            end
        end
    end
`else
    logic unused_iaddr;
    assign unused_iaddr = ^iaddr;
`endif

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed scoreboard bench for mult_div_unit.
module tb_mult_div_unit;
    import md_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] iaddr;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    int errors = 0;
    int checks = 0;
    logic [63:0] sb[$];

    mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .iaddr (iaddr),
        .busy  (busy),
        .hi    (hi),
        .lo    (lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue a multi-cycle op, optionally poke a start during busy cycle
    // poke_at, then check latency, hold of old hi/lo and the committed value.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] va,
                          input logic [31:0] vb, input logic [63:0] exp, input int lat,
                          input int poke_at, input logic [2:0] poke_op,
                          input logic [31:0] poke_a);
        logic [63:0] old;
        logic [63:0] want;
        int n;
        old = {hi, lo};
        sb.push_back(exp);
        start = 1'b1; op = o; a = va; b = vb; iaddr = iaddr + 32'd4;
        tick();
        start = 1'b0;
        check({tag, "_busy_rise"}, {63'd0, busy}, 64'd1);
        n = 0;
        while (busy && n < 100) begin
            check({tag, "_hold"}, {hi, lo}, old);
            if (n == poke_at) begin
                start = 1'b1; op = poke_op; a = poke_a;
            end else begin
                start = 1'b0;
            end
            tick();
            n++;
        end
        start = 1'b0;
        check({tag, "_latency"}, 64'(n), 64'(lat));
        want = sb.pop_front();
        check({tag, "_result"}, {hi, lo}, want);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0; iaddr = 32'h0040_0000;
        tick();
        tick();
        reset = 1'b0;
        check("reset_hilo", {hi, lo}, 64'd0);
        check("reset_busy", {63'd0, busy}, 64'd0);

        // MTHI / MTLO / reserved op
        start = 1'b1; op = MD_MTHI; a = 32'h1234_5678;
        tick();
        start = 1'b0;
        check("mthi", {hi, lo}, {32'h1234_5678, 32'd0});
        check("mthi_busy", {63'd0, busy}, 64'd0);
        start = 1'b1; op = MD_MTLO; a = 32'hCAFE_0001;
        tick();
        start = 1'b0;
        check("mtlo", {hi, lo}, {32'h1234_5678, 32'hCAFE_0001});
        start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF; b = 32'd9;
        tick();
        start = 1'b1; op = 3'd7;
        tick();
        start = 1'b0;
        check("reserved", {hi, lo}, {32'h1234_5678, 32'hCAFE_0001});
        check("reserved_busy", {63'd0, busy}, 64'd0);

        // Arithmetic cases
        run_op("mult_neg", MD_MULT, 32'hFFFF_FFFE, 32'd3,
               {32'hFFFF_FFFF, 32'hFFFF_FFFA}, 5, -1, MD_MTHI, 32'd0);
        run_op("divu_zero", MD_DIVU, 32'd7, 32'd0,
               {32'd7, 32'hFFFF_FFFF}, 10, -1, MD_MTHI, 32'd0);
        tick();
        run_op("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2,
               {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 10, -1, MD_MTHI, 32'd0);
        tick();
        run_op("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
               {32'd0, 32'h8000_0000}, 10, 2, MD_MTLO, 32'd5);
        tick();
        run_op("divu_basic", MD_DIVU, 32'd100, 32'd7,
               {32'd2, 32'd14}, 10, -1, MD_MTHI, 32'd0);
        tick();
        run_op("div_zero", MD_DIV, 32'hFFFF_FF00, 32'd0,
               {32'hFFFF_FF00, 32'hFFFF_FFFF}, 10, -1, MD_MTHI, 32'd0);
        tick();

        // Reset during an in-flight MULTU cancels the commit
        start = 1'b1; op = MD_MULTU; a = 32'd100000; b = 32'd100000;
        tick();
        start = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        start = 1'b1; op = MD_MTHI; a = 32'h5555_AAAA;
        tick();
        reset = 1'b0; start = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        repeat (6) tick();
        check("rst_no_commit", {hi, lo}, 64'd0);
        check("rst_idle", {63'd0, busy}, 64'd0);

        // Start on the commit edge is dropped; next op the cycle after
        run_op("multu_a", MD_MULTU, 32'd100000, 32'd100000,
               {32'd2, 32'h540B_E400}, 5, 4, MD_MTHI, 32'hDEAD_0000);
        run_op("multu_b", MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
               {32'hFFFF_FFFE, 32'h0000_0001}, 5, -1, MD_MTHI, 32'd0);
        check("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
